// File: rtl/morse_pkg.sv
// Shared definitions for the Morse capture front end and the downstream letter lookup.
// Holds symbol/state encodings and the packed code-word type.
package morse_pkg;

  localparam int MAX_SYMBOLS = 5;
  localparam int LEN_W       = 3;

  typedef enum logic {
    SYM_DOT  = 1'b0,
    SYM_DASH = 1'b1
  } symbol_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0]       len;
    logic [MAX_SYMBOLS-1:0] bits;
  } code_word_t;

  // Appends a symbol at position len; callers guarantee len < MAX_SYMBOLS.
  function automatic code_word_t push_symbol(code_word_t w, symbol_e s);
    code_word_t r;
    r = w;
    r.bits[w.len] = s;
    r.len = w.len + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/morse_symbol_capture_if.sv
// Button inputs and capture outputs of the Morse front end, bundled for port connection.
// master = capture block, slave = button source / code-word consumer.
interface morse_symbol_capture_if;
  import morse_pkg::*;

  logic                   dot_btn;
  logic                   dash_btn;
  logic                   done_btn;
  logic                   dot_pulse;
  logic                   dash_pulse;
  logic [MAX_SYMBOLS-1:0] code_bits;
  logic [LEN_W-1:0]       code_len;
  logic                   code_valid;
  logic                   overflow;
  logic                   busy;

  modport master (
    input  dot_btn, dash_btn, done_btn,
    output dot_pulse, dash_pulse, code_bits, code_len, code_valid, overflow, busy
  );

  modport slave (
    output dot_btn, dash_btn, done_btn,
    input  dot_pulse, dash_pulse, code_bits, code_len, code_valid, overflow, busy
  );

endinterface

// File: rtl/morse_symbol_capture_button_conditioner.sv
// One push-button: 2-FF synchroniser, stability-count debounce, one-cycle press on rising level.
// Presses are suppressed until the button has been seen released after reset.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic             armed_q, armed_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // fill_q marks when sync_q holds real samples rather than reset zeros
    armed_d = armed_q | (fill_q[1] & ~sync_q[1]);
    press_d = level_d & ~level_q & armed_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/morse_symbol_capture.sv
// Morse front end: conditions dot/dash/done buttons and accumulates symbols into a code word,
// committed on done or after an inactivity timeout.
module morse_symbol_capture
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 150_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  morse_symbol_capture_if.master bus
);

  localparam int BTN_DOT  = 0;
  localparam int BTN_DASH = 1;
  localparam int BTN_DONE = 2;

  localparam int               IDLE_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_SYMBOLS);

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {bus.done_btn, bus.dash_btn, bus.dot_btn};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cond (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_raw[gi]),
        .press_o(press[gi])
      );
    end
  endgenerate

  state_e            state_q, state_d;
  code_word_t        word_q, word_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              ovf_d;
  logic              overflow_q;
  logic              dot_pulse_q, dash_pulse_q;
  logic              sym_valid;
  logic              done_press;
  symbol_e           sym;

  // Coincident dot and dash cancel each other out.
  assign sym_valid  = press[BTN_DOT] ^ press[BTN_DASH];
  assign sym        = press[BTN_DASH] ? SYM_DASH : SYM_DOT;
  assign done_press = press[BTN_DONE];

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idle_d  = idle_q;
    ovf_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sym_valid) begin
          word_d  = push_symbol('0, sym);
          idle_d  = '0;
          state_d = done_press ? EMIT : COLLECT;
        end
      end
      COLLECT: begin
        if (sym_valid) begin
          if (word_q.len < LEN_MAX) begin
            word_d  = push_symbol(word_q, sym);
            idle_d  = '0;
            state_d = done_press ? EMIT : COLLECT;
          end else begin
            ovf_d   = 1'b1;
            word_d  = '0;
            idle_d  = '0;
            state_d = IDLE;
          end
        end else if (done_press) begin
          state_d = EMIT;
        end else if ((TIMEOUT_CYCLES != 0) && (idle_q == IDLE_LAST)) begin
          state_d = EMIT;
        end else if (idle_q != '1) begin
          idle_d = idle_q + 1'b1;
        end
      end
      EMIT: begin
        // word_q stays frozen for this cycle; a symbol here opens the next word
        word_d  = '0;
        idle_d  = '0;
        state_d = IDLE;
        if (sym_valid) begin
          word_d  = push_symbol('0, sym);
          state_d = done_press ? EMIT : COLLECT;
        end
      end
      default: begin
        word_d  = '0;
        idle_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      word_q       <= '0;
      idle_q       <= '0;
      overflow_q   <= 1'b0;
      dot_pulse_q  <= 1'b0;
      dash_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idle_q       <= idle_d;
      overflow_q   <= ovf_d;
      dot_pulse_q  <= press[BTN_DOT] & ~press[BTN_DASH];
      dash_pulse_q <= press[BTN_DASH] & ~press[BTN_DOT];
    end
  end

  assign bus.code_valid = (state_q == EMIT);
  assign bus.code_bits  = (state_q == EMIT) ? word_q.bits : '0;
  assign bus.code_len   = (state_q == EMIT) ? word_q.len : '0;
  assign bus.busy       = (state_q == COLLECT);
  assign bus.overflow   = overflow_q;
  assign bus.dot_pulse  = dot_pulse_q;
  assign bus.dash_pulse = dash_pulse_q;

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Scoreboard bench for morse_symbol_capture: stimulus queues expected pulses and code words,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_morse_symbol_capture;

  localparam int K_DOT  = 0;
  localparam int K_DASH = 1;
  localparam int K_OVF  = 2;

  typedef struct {
    int len;
    int bits;
    int gap;
  } exp_word_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   last_sym;
  logic prev_busy;

  exp_word_t wq[$];
  int        pq[$];

  morse_symbol_capture_if bus();

  morse_symbol_capture #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_pulse(input int kind);
    int e;
    n_cmp++;
    if (pq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_pulse: got kind %0d required none (cycle %0d)", kind, cyc);
    end else begin
      e = pq.pop_front();
      n_cmp--;
      check("pulse_kind", kind, e);
      $display("pulse kind=%0d at cycle %0d", kind, cyc);
    end
  endtask

  // Monitor: the only consumer of the expectation queues.
  always @(negedge clk) begin
    exp_word_t w;
    if (bus.dot_pulse) begin
      pop_pulse(K_DOT);
      last_sym = cyc;
    end
    if (bus.dash_pulse) begin
      pop_pulse(K_DASH);
      last_sym = cyc;
    end
    if (bus.overflow) pop_pulse(K_OVF);
    if (bus.code_valid) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_code_valid: got len=%0d bits=%b required no strobe (cycle %0d)",
                 bus.code_len, bus.code_bits, cyc);
      end else begin
        w = wq.pop_front();
        check("code_len", int'(bus.code_len), w.len);
        check("code_bits", int'(bus.code_bits), w.bits);
        check("busy_at_strobe", int'(bus.busy), 0);
        check("busy_before_strobe", int'(prev_busy), 1);
        if (w.gap >= 0) check("timeout_gap", cyc - last_sym, w.gap);
        $display("word len=%0d bits=%b at cycle %0d", bus.code_len, bus.code_bits, cyc);
      end
    end else begin
      check("held_zero", int'({bus.code_len, bus.code_bits}), 0);
    end
    prev_busy = bus.busy;
  end

  task automatic push_word(input int len, input int bits, input int gap);
    exp_word_t w;
    w.len  = len;
    w.bits = bits;
    w.gap  = gap;
    wq.push_back(w);
  endtask

  task automatic press(input logic d, input logic h, input logic n);
    bus.dot_btn  = d;
    bus.dash_btn = h;
    bus.done_btn = n;
    repeat (7) @(negedge clk);
    bus.dot_btn  = 1'b0;
    bus.dash_btn = 1'b0;
    bus.done_btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (40) @(negedge clk);
    check({name, "_words_left"}, wq.size(), 0);
    check({name, "_pulses_left"}, pq.size(), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    last_sym = 0;
    prev_busy = 1'b0;
    reset = 1'b0;
    bus.dot_btn = 1'b0;
    bus.dash_btn = 1'b0;
    bus.done_btn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code_valid", int'(bus.code_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_dot_pulse", int'(bus.dot_pulse), 0);
    check("rst_dash_pulse", int'(bus.dash_pulse), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 1: bouncing dot settles into a single press, then times out as a one-dot word
    pq.push_back(K_DOT);
    push_word(1, 0, 20);
    for (int i = 0; i < 6; i++) begin
      bus.dot_btn = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    bus.dot_btn = 1'b1;
    repeat (10) @(negedge clk);
    check("t1_busy", int'(bus.busy), 1);
    bus.dot_btn = 1'b0;
    drain("t1");

    // 2: letter A
    pq.push_back(K_DOT);
    pq.push_back(K_DASH);
    push_word(2, 5'b00010, -1);
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    drain("t2");

    // 3: three dashes committed by the timeout
    repeat (3) pq.push_back(K_DASH);
    push_word(3, 5'b00111, 20);
    repeat (3) press(0, 1, 0);
    drain("t3");

    // 4: six dots overflow, then a fresh single dot
    repeat (6) pq.push_back(K_DOT);
    pq.push_back(K_OVF);
    repeat (6) press(1, 0, 0);
    check("t4_idle_after_overflow", int'(bus.busy), 0);
    pq.push_back(K_DOT);
    push_word(1, 0, -1);
    press(1, 0, 0);
    press(0, 0, 1);
    drain("t4");

    // 5a: done in IDLE does nothing
    press(0, 0, 1);
    drain("t5a");
    // 5b: dot+dash together are discarded
    pq.push_back(K_DOT);
    push_word(1, 0, -1);
    press(1, 0, 0);
    press(1, 1, 0);
    press(0, 0, 1);
    drain("t5b");
    // 5c: dash arriving with done is included in the word
    pq.push_back(K_DOT);
    pq.push_back(K_DASH);
    push_word(2, 5'b00010, -1);
    press(1, 0, 0);
    press(0, 1, 1);
    drain("t5c");

    // 6: asynchronous reset mid-word discards the buffer
    pq.push_back(K_DOT);
    pq.push_back(K_DASH);
    press(1, 0, 0);
    press(0, 1, 0);
    check("t6_busy_before_reset", int'(bus.busy), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("t6_rst_busy", int'(bus.busy), 0);
    check("t6_rst_code_valid", int'(bus.code_valid), 0);
    check("t6_rst_code_len", int'(bus.code_len), 0);
    check("t6_rst_code_bits", int'(bus.code_bits), 0);
    check("t6_rst_overflow", int'(bus.overflow), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    press(0, 0, 1);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_symbol_capture.md
Name: morse_symbol_capture

Overview:
Upstream front end of the Morse letter decoder. It conditions the raw dot/dash/done push-buttons (synchronise, debounce, edge-detect) and accumulates dot/dash symbols into a bounded code word. It emits the word as {code_len, code_bits} with a one-cycle valid pulse, on a done press or after an inactivity timeout. Per-press pulses are also exported so the display pages can echo keystrokes.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles an input must hold stable before the debounced level changes (10 ms at 100 MHz)
TIMEOUT_CYCLES, 150_000_000, idle cycles in COLLECT before auto-commit; 0 disables the timeout
MAX_SYMBOLS, 5, maximum symbols per code word (letters plus digits)

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-low reset
dot_btn  in  1  raw dot button, asynchronous to clk
dash_btn  in  1  raw dash button, asynchronous to clk
done_btn  in  1  raw done button, asynchronous to clk
dot_pulse  out  1  one-cycle pulse per accepted dot
dash_pulse  out  1  one-cycle pulse per accepted dash
code_bits  out  MAX_SYMBOLS  symbol i in bit i (first symbol = bit 0); 1 = dash, 0 = dot; unused bits 0
code_len  out  3  number of valid symbols, 1..MAX_SYMBOLS, while code_valid is high
code_valid  out  1  one-cycle commit strobe
overflow  out  1  one-cycle pulse when a symbol is pushed onto a full buffer
busy  out  1  high while in COLLECT

Behaviour:
- Reset (reset = 0, asynchronous assert, synchronous release): all outputs 0, buffer empty, state IDLE, all counters 0, debounced levels 0.
- Input conditioning, per button:
  - 2-FF synchroniser.
  - Debounce counter resets whenever the synchronised value equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A rising edge of the debounced level gives a one-cycle internal press. A release generates nothing.
- Press arbitration, same cycle:
  - dot and dash together: both discarded, overflow not raised, no pulses.
  - done plus dot or dash: the symbol is appended first, then done is applied. The committed word includes that symbol.
- dot_pulse and dash_pulse are registered, so they assert 1 cycle after the internal press.
- FSM states:
  - IDLE:
    - dot/dash: buf[0] = symbol, len = 1, go to COLLECT.
    - done: ignored (an empty word is never emitted).
  - COLLECT:
    - dot/dash with len < MAX_SYMBOLS: buf[len] = symbol, len += 1, idle counter cleared.
    - dot/dash with len == MAX_SYMBOLS: overflow pulses next cycle, buffer cleared, go to IDLE, no emit.
    - done: go to EMIT.
    - idle counter == TIMEOUT_CYCLES-1, with TIMEOUT_CYCLES != 0: go to EMIT.
    - The idle counter increments every COLLECT cycle without a symbol.
  - EMIT, one cycle:
    - code_valid = 1, with code_bits and code_len holding the frozen word.
    - Next state is IDLE with the buffer cleared.
    - A dot/dash pressed in the EMIT cycle starts a new word (len = 1, COLLECT).
- Latency: code_valid asserts exactly 1 cycle after the accepting done press, or after the timeout cycle.
- code_bits and code_len are valid only while code_valid is high. Between strobes they are held at 0.
- Counter widths are $clog2(param+1). There is no wrap: counters saturate and clear as stated above.
- Reset mid-word discards the buffer with no code_valid. Buttons held through reset release are not seen as presses until released and pressed again.

Decomposition:
- morse_pkg holds:
  - MAX_SYMBOLS
  - symbol encoding (SYM_DOT = 0, SYM_DASH = 1)
  - FSM state encodings IDLE/COLLECT/EMIT
  - the code-word type {len[2:0], bits[4:0]}
  The downstream letter lookup uses the same package.
- Sub-module button_conditioner (synchroniser + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES) is instantiated three times.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES = 4, TIMEOUT_CYCLES = 20.)
1. Bounce: toggle dot_btn every 2 cycles for 12 cycles, then hold high for 10 cycles -> exactly one dot_pulse, busy = 1, no code_valid.
2. Letter "A": press dot, dash, done -> code_valid once with code_len = 2, code_bits = 5'b00010. Strobe lands 1 cycle after the done press; busy falls in the same cycle.
3. Timeout: press dash, dash, dash, then idle -> code_valid on the 20th COLLECT cycle after the last dash, with code_len = 3, code_bits = 5'b00111.
4. Overflow: press 6 dots -> overflow pulses once after the 6th dot, no code_valid, state IDLE. A following dot + done gives code_len = 1, code_bits = 0.
5. Simultaneous/empty cases: done in IDLE -> no outputs. dot and dash on the same cycle -> no pulses, len unchanged. done together with dash while len = 1 (dot) -> code_len = 2, code_bits = 5'b00010.
6. Reset mid-word: dot, dash, then reset low for 3 cycles asynchronously to clk -> all outputs 0 immediately. After release, done produces no code_valid.
